cacheline_arbiter: RTL and testbench
====================================

Name: cacheline_arbiter

Overview:
- Shares the single 256-bit cacheline memory port between the instruction cache (I) and data cache (D) downstream ports.
- Sits between the two caches' dfp_* interfaces and the memory/burst adapter.
- Grants one requester at a time and holds the grant until memory responds. Arbitration is round-robin.
- Routes the response and read data back to the owner only, and flags memory transactions that exceed a timeout.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- LINE_WIDTH, 256, cacheline data width.
- TIMEOUT_CYCLES, 1024, busy cycles without mem_resp before timeout_err sets; must be >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset: 0 resets, 1 runs
- i_addr  in  ADDR_WIDTH  icache line address
- i_read  in  1  icache read request
- i_write  in  1  icache write request (normally 0)
- i_wdata  in  LINE_WIDTH  icache write line
- i_rdata  out  LINE_WIDTH  line returned to icache
- i_resp  out  1  icache response
- d_addr, d_read, d_write, d_wdata, d_rdata, d_resp: same set for the dcache
- mem_addr  out  ADDR_WIDTH  memory address
- mem_read  out  1  memory read
- mem_write  out  1  memory write
- mem_wdata  out  LINE_WIDTH  memory write line
- mem_rdata  in  LINE_WIDTH  memory read line
- mem_resp  in  1  memory response, 1 cycle
- timeout_err  out  1  sticky timeout flag
- grant_d  out  1  1 while the dcache owns the port (debug)

Behaviour:
- Request definition: req_x = x_read | x_write. Requesters hold addr/read/write/wdata stable from assertion until their resp.
- States:
  - IDLE: no owner. All mem_* outputs are 0.
  - BUSY_I: mem_* is driven from the i_* inputs.
  - BUSY_D: mem_* is driven from the d_* inputs.
- Transitions out of IDLE:
  - Only req_i: go to BUSY_I.
  - Only req_d: go to BUSY_D.
  - Both: the side indicated by rr_ptr wins (rr_ptr = 0 favours I). The transition is registered, so the first mem_read/mem_write appears one cycle after the request is seen.
  - Neither: stay in IDLE.
- BUSY_x:
  - mem_addr/read/write/wdata are combinationally equal to x's inputs.
  - On mem_resp: x_resp = 1 in the same cycle, next state is IDLE, and rr_ptr points to the other side (BUSY_I sets 1, BUSY_D sets 0).
  - No mem_resp: stay in BUSY_x.
- Responses: i_rdata and d_rdata both equal mem_rdata at all times. Only the owner's resp can be 1. The non-owner's resp is 0 always, even on mem_resp. A mem_resp in IDLE is ignored: no resp issued, no state change.
- Back-to-back requests: a requester re-asserting in the cycle after its resp competes normally. With both requesting continuously, grants alternate I, D, I, D, with one IDLE bubble between transactions.
- Requester drops its request mid-BUSY (protocol violation): arbiter stays busy and keeps forwarding the owner's current inputs until mem_resp.
- x_read and x_write both high: forwarded unchanged to memory. The bench flags this as an error.
- Timeout:
  - busy_cnt clears on entering BUSY_x and increments each BUSY cycle without mem_resp, saturating at TIMEOUT_CYCLES.
  - When busy_cnt reaches TIMEOUT_CYCLES, timeout_err sets and stays set until reset. The transaction is not aborted.
- grant_d = 1 in BUSY_D only.
- Reset (rst = 0 at a clock edge, including mid-transaction): the cycle after, state is IDLE, rr_ptr = 0, busy_cnt = 0, timeout_err = 0, all mem_* = 0, i_resp = d_resp = 0, grant_d = 0. An in-flight memory response after reset is ignored by the IDLE rule.

Optional Feature:
- Macro: CACHELINE_ARB_DPRIORITY_EN.
- Defined: fixed priority replaces round-robin.
  - When both request in IDLE, D always wins.
  - To bound I starvation, a 3-bit counter counts consecutive D grants made while req_i = 1. When it reaches 4, the next contested grant goes to I and the counter clears.
  - The counter also clears on any I grant and on reset.
- Not defined: round-robin as described above; no starvation counter is instantiated.

Test Plan:
- Reset then single icache read (i_addr = 0x0000_1000): mem_read = 1 and mem_addr = 0x0000_1000 from cycle 1. Memory responds at cycle 5 with mem_rdata = 0xA5 pattern: i_resp = 1 and i_rdata = pattern in that cycle; d_resp stays 0; state returns to IDLE.
- i_read and d_write asserted in the same cycle after reset (rr_ptr = 0): I is served first. After I's resp there is 1 IDLE cycle, then mem_write = 1 with mem_addr = d_addr and mem_wdata = d_wdata; d_resp = 1 on the second mem_resp.
- Both requesting continuously, memory latency 3: grant order I, D, I, D. With CACHELINE_ARB_DPRIORITY_EN the order is D, D, D, D, I, D, ...
- Stray mem_resp pulse in IDLE: i_resp = d_resp = 0, no state change, no mem request.
- TIMEOUT_CYCLES = 8, dcache read with no memory response: timeout_err = 1 after the 8th busy cycle and stays set. A later mem_resp still gives d_resp = 1 and timeout_err remains 1.
- rst = 0 asserted during BUSY_D: the next cycle shows all outputs 0 and IDLE. A following i_read is granted first because rr_ptr reset to 0.

Source files
------------

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between the icache and dcache.
// Define CACHELINE_ARB_DPRIORITY_EN for dcache priority with a bounded icache starvation counter.
module cacheline_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,

    output logic                  timeout_err,
    output logic                  grant_d
);

    localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_busy_cnt;
    logic [CNT_W-1:0] w_busy_cnt_nxt;
    logic             r_timeout_err;
    logic             w_req_i;
    logic             w_req_d;
    logic             w_pick_d;

`ifdef CACHELINE_ARB_DPRIORITY_EN
    logic [2:0] r_starve_cnt;
    logic [2:0] w_starve_nxt;
`else
    logic       r_rr_ptr;
    logic       w_rr_nxt;
`endif

    assign w_req_i = i_read | i_write;
    assign w_req_d = d_read | d_write;

`ifdef CACHELINE_ARB_DPRIORITY_EN
    // D wins contested grants until four in a row have starved I.
    assign w_pick_d = (r_starve_cnt < 3'd4);
`else
    assign w_pick_d = r_rr_ptr;
`endif

    // Read data is broadcast; only the owner's resp qualifies it.
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;
    assign timeout_err = r_timeout_err;

    always_comb begin
        w_state_nxt = r_state;
        mem_addr    = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wdata   = '0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        grant_d     = 1'b0;
`ifdef CACHELINE_ARB_DPRIORITY_EN
        w_starve_nxt = r_starve_cnt;
`else
        w_rr_nxt     = r_rr_ptr;
`endif

        case (r_state)
            IDLE: begin
                if (w_req_i && w_req_d) begin
                    w_state_nxt = w_pick_d ? BUSY_D : BUSY_I;
                end else if (w_req_i) begin
                    w_state_nxt = BUSY_I;
                end else if (w_req_d) begin
                    w_state_nxt = BUSY_D;
                end
`ifdef CACHELINE_ARB_DPRIORITY_EN
                if (w_state_nxt == BUSY_I) begin
                    w_starve_nxt = 3'd0;
                end else if (w_state_nxt == BUSY_D && w_req_i && r_starve_cnt != 3'd7) begin
                    w_starve_nxt = r_starve_cnt + 3'd1;
                end
`endif
            end

            BUSY_I: begin
                mem_addr  = i_addr;
                mem_read  = i_read;
                mem_write = i_write;
                mem_wdata = i_wdata;
                if (mem_resp) begin
                    i_resp      = 1'b1;
                    w_state_nxt = IDLE;
`ifndef CACHELINE_ARB_DPRIORITY_EN
                    w_rr_nxt    = 1'b1;
`endif
                end
            end

            BUSY_D: begin
                mem_addr  = d_addr;
                mem_read  = d_read;
                mem_write = d_write;
                mem_wdata = d_wdata;
                grant_d   = 1'b1;
                if (mem_resp) begin
                    d_resp      = 1'b1;
                    w_state_nxt = IDLE;
`ifndef CACHELINE_ARB_DPRIORITY_EN
                    w_rr_nxt    = 1'b0;
`endif
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Counter is held at zero while idle, so it starts from zero on every grant.
    always_comb begin
        w_busy_cnt_nxt = r_busy_cnt;
        if (r_state == IDLE) begin
            w_busy_cnt_nxt = '0;
        end else if (!mem_resp && r_busy_cnt != TMO) begin
            w_busy_cnt_nxt = r_busy_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_busy_cnt    <= '0;
            r_timeout_err <= 1'b0;
`ifdef CACHELINE_ARB_DPRIORITY_EN
            r_starve_cnt  <= 3'd0;
`else
            r_rr_ptr      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_busy_cnt <= w_busy_cnt_nxt;
            if (w_busy_cnt_nxt == TMO) begin
                r_timeout_err <= 1'b1;
            end
`ifdef CACHELINE_ARB_DPRIORITY_EN
            r_starve_cnt <= w_starve_nxt;
`else
            r_rr_ptr     <= w_rr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Scoreboard bench for cacheline_arbiter: directed stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever i_resp or d_resp is presented.
module tb_cacheline_arbiter;

    localparam int AW  = 32;
    localparam int LW  = 256;
    localparam int TMO = 8;

`ifdef CACHELINE_ARB_DPRIORITY_EN
    localparam bit DPRIO = 1'b1;
`else
    localparam bit DPRIO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_read = 1'b0;
    logic          i_write = 1'b0;
    logic [LW-1:0] i_wdata = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic [AW-1:0] d_addr = '0;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic [AW-1:0] mem_addr;
    logic          mem_read;
    logic          mem_write;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata = '0;
    logic          mem_resp = 1'b0;
    logic          timeout_err;
    logic          grant_d;

    always #5 clk = ~clk;

    cacheline_arbiter #(
        .ADDR_WIDTH    (AW),
        .LINE_WIDTH    (LW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_addr     (i_addr),
        .i_read     (i_read),
        .i_write    (i_write),
        .i_wdata    (i_wdata),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_addr     (d_addr),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp),
        .timeout_err(timeout_err),
        .grant_d    (grant_d)
    );

    typedef struct packed {
        logic          who;   // 0 = icache, 1 = dcache
        logic [LW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   bcnt     = 0;
    int   mem_lat  = 3;
    bit   mem_auto = 1'b0;

    function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
        return {8{a ^ 32'hA5A5_A5A5}};
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic push(input logic who, input logic [AW-1:0] a);
        exp_t e;
        e.who  = who;
        e.data = pat(a);
        exp_q.push_back(e);
    endtask

    // One clock; memory model answers mem_lat cycles into each transaction when enabled.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_resp) begin
            mem_resp  = 1'b0;
            mem_rdata = '0;
            bcnt      = 0;
        end else if (mem_auto && (mem_read || mem_write)) begin
            bcnt++;
            if (bcnt >= mem_lat) begin
                mem_resp  = 1'b1;
                mem_rdata = pat(mem_addr);
            end
        end
        #1;
    endtask

    task automatic wait_resp(input int budget);
        for (int k = 0; k < budget; k++) begin
            tick();
            if (i_resp || d_resp) return;
        end
        chk1("resp_wait_budget", 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        mem_resp = 1'b0;
        bcnt     = 0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, "_mem_read"}, mem_read, 1'b0);
        chk1({tag, "_mem_write"}, mem_write, 1'b0);
        chk({tag, "_mem_addr"}, LW'(mem_addr), '0);
        chk({tag, "_mem_wdata"}, mem_wdata, '0);
        chk1({tag, "_i_resp"}, i_resp, 1'b0);
        chk1({tag, "_d_resp"}, d_resp, 1'b0);
        chk1({tag, "_grant_d"}, grant_d, 1'b0);
    endtask

    always @(negedge clk) begin
        if (i_resp || d_resp) begin
            chk1("resp_exclusive", i_resp & d_resp, 1'b0);
            if (exp_q.size() == 0) begin
                chk1("resp_unexpected", 1'b1, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                chk1("resp_owner_is_d", d_resp, mon_e.who);
                chk("resp_rdata", mon_e.who ? d_rdata : i_rdata, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic          first_d;
        logic [AW-1:0] a_first;
        logic [AW-1:0] a_second;
        logic [LW-1:0] w_first;
        logic [LW-1:0] w_second;
        logic [LW-1:0] d_pat;
        int            c1;
        logic          order[6];

        d_pat = {8{32'hDEAD_BEEF}};

        // Reset state
        do_reset();
        chk_idle("rst");
        chk1("rst_timeout_err", timeout_err, 1'b0);

        // Single icache read, response in the fifth busy cycle
        mem_auto = 1'b1;
        mem_lat  = 5;
        i_addr   = 32'h0000_1000;
        i_read   = 1'b1;
        push(1'b0, 32'h0000_1000);
        tick();
        c1 = cyc;
        chk1("t1_mem_read", mem_read, 1'b1);
        chk("t1_mem_addr", LW'(mem_addr), LW'(32'h0000_1000));
        chk1("t1_grant_d", grant_d, 1'b0);
        chk1("t1_early_resp", i_resp, 1'b0);
        wait_resp(10);
        chk("t1_resp_cycle", LW'(cyc - c1), LW'(4));
        chk1("t1_i_resp", i_resp, 1'b1);
        chk1("t1_d_resp", d_resp, 1'b0);
        tick();
        i_read = 1'b0;
        chk_idle("t1_after");

        // Simultaneous icache read and dcache write after reset
        do_reset();
        mem_lat = 3;
        first_d = DPRIO;
        i_addr  = 32'h0000_2000;
        i_read  = 1'b1;
        d_addr  = 32'h0000_3000;
        d_wdata = d_pat;
        d_write = 1'b1;
        a_first  = first_d ? 32'h0000_3000 : 32'h0000_2000;
        a_second = first_d ? 32'h0000_2000 : 32'h0000_3000;
        w_first  = first_d ? d_pat : '0;
        w_second = first_d ? '0 : d_pat;
        push(first_d, a_first);
        push(!first_d, a_second);
        tick();
        chk1("t2_first_grant_d", grant_d, first_d);
        chk("t2_first_addr", LW'(mem_addr), LW'(a_first));
        chk1("t2_first_write", mem_write, first_d);
        chk1("t2_first_read", mem_read, !first_d);
        chk("t2_first_wdata", mem_wdata, w_first);
        wait_resp(10);
        tick();
        if (first_d) d_write = 1'b0;
        else         i_read  = 1'b0;
        chk1("t2_bubble_read", mem_read, 1'b0);
        chk1("t2_bubble_write", mem_write, 1'b0);
        tick();
        chk1("t2_second_grant_d", grant_d, !first_d);
        chk("t2_second_addr", LW'(mem_addr), LW'(a_second));
        chk1("t2_second_write", mem_write, !first_d);
        chk("t2_second_wdata", mem_wdata, w_second);
        wait_resp(10);
        tick();
        i_read  = 1'b0;
        d_write = 1'b0;
        d_wdata = '0;

        // Both requesting continuously, latency 3
        if (DPRIO) order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        else       order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        i_addr = 32'h0000_0100;
        d_addr = 32'h0000_0200;
        for (int k = 0; k < 6; k++) push(order[k], order[k] ? 32'h0000_0200 : 32'h0000_0100);
        i_read = 1'b1;
        d_read = 1'b1;
        for (int k = 0; k < 6; k++) wait_resp(12);
        tick();
        i_read = 1'b0;
        d_read = 1'b0;
        tick();
        chk_idle("t3_after");

        // Stray mem_resp while idle
        mem_resp  = 1'b1;
        mem_rdata = pat(32'h0000_7777);
        #1;
        chk_idle("t4_stray");
        tick();
        chk_idle("t4_after");

        // Timeout with TIMEOUT_CYCLES = 8, dcache read never answered until late
        mem_auto = 1'b0;
        d_addr   = 32'h0000_4000;
        d_read   = 1'b1;
        tick();
        chk1("t5_grant_d", grant_d, 1'b1);
        chk1("t5_err_b1", timeout_err, 1'b0);
        for (int b = 2; b <= 8; b++) tick();
        chk1("t5_err_b8", timeout_err, 1'b0);
        tick();
        chk1("t5_err_b9", timeout_err, 1'b1);
        tick();
        tick();
        tick();
        chk1("t5_err_b12", timeout_err, 1'b1);
        chk1("t5_still_busy", mem_read, 1'b1);
        push(1'b1, 32'h0000_4000);
        mem_resp  = 1'b1;
        mem_rdata = pat(mem_addr);
        #1;
        chk1("t5_d_resp", d_resp, 1'b1);
        tick();
        d_read = 1'b0;
        chk1("t5_err_sticky", timeout_err, 1'b1);
        chk1("t5_idle_grant_d", grant_d, 1'b0);

        // Reset during BUSY_D after an icache transaction moved the pointer to D
        mem_auto = 1'b1;
        mem_lat  = 2;
        i_addr   = 32'h0000_6000;
        i_read   = 1'b1;
        push(1'b0, 32'h0000_6000);
        wait_resp(10);
        tick();
        i_read   = 1'b0;
        mem_auto = 1'b0;
        d_addr   = 32'h0000_5000;
        d_read   = 1'b1;
        tick();
        chk1("t6_busy_d", grant_d, 1'b1);
        rst    = 1'b0;
        i_read = 1'b1;
        tick();
        chk_idle("t6_rst");
        chk1("t6_rst_err", timeout_err, 1'b0);
        push(DPRIO, DPRIO ? 32'h0000_5000 : 32'h0000_6000);
        push(!DPRIO, DPRIO ? 32'h0000_6000 : 32'h0000_5000);
        rst      = 1'b1;
        mem_auto = 1'b1;
        tick();
        chk1("t6_first_grant_d", grant_d, DPRIO);
        chk("t6_first_addr", LW'(mem_addr), LW'(DPRIO ? 32'h0000_5000 : 32'h0000_6000));
        wait_resp(10);
        tick();
        if (DPRIO) d_read = 1'b0;
        else       i_read = 1'b0;
        wait_resp(10);
        tick();
        i_read = 1'b0;
        d_read = 1'b0;
        tick();
        chk_idle("t6_after");

        chk("sb_queue_empty", LW'(exp_q.size()), '0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
